// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: latch state encoding, default widths and
// per-stage payload layouts that are cast to DATA_W at each latch instance.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } latch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [18:0] imm;
    logic [31:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [18:0] rsvd;
    logic [31:0] alu_res;
  } ex_mem_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [18:0] rsvd;
    logic [31:0] wb_data;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_latch.sv
// Inter-stage valid/ready latch with a two-entry skid buffer, flush, global
// freeze and a saturating stall-cycle counter.
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   FULL  | one entry in main reg, can still accept
//   SKID  | main and skid regs both held, in_ready low
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  latch_state_t      state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              accept, consume, stall;

  // Handshake outputs come from the state register only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = enable & (state != SKID);
  assign out_valid = enable & (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    cnt_nxt   = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    if (flush) begin
      state_nxt = EMPTY;
    end else if (enable) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = FULL;
            main_nxt  = in_data;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_nxt = in_data;
          end else if (accept) begin
            state_nxt = SKID;
            skid_nxt  = in_data;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        SKID: begin
          if (consume) begin
            state_nxt = FULL;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Scoreboard bench for pipe_skid_latch: a FIFO model fed on accept, a negedge
// monitor comparing both a 16-bit-counter and a 4-bit-counter instance.
module tb_pipe_skid_latch;

  logic        clk = 1'b0;
  logic        rst, enable, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic        ir, ov, ir4, ov4;
  logic [63:0] od, od4;
  logic [15:0] sc;
  logic [3:0]  sc4;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  int          cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_latch #(.DATA_W(64), .CNT_W(16)) u_dut (
    .CLK(clk), .RST(rst), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir),
    .out_valid(ov), .out_data(od), .out_ready(out_ready), .stall_cnt(sc)
  );

  pipe_skid_latch #(.DATA_W(64), .CNT_W(4)) u_sat (
    .CLK(clk), .RST(rst), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(out_ready), .stall_cnt(sc4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pushes expected payloads on accept, pops on consume.
  always @(posedge clk) begin
    bit m_ov, m_ir;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      m_ov = enable && (q.size() > 0);
      m_ir = enable && (q.size() < 2);
      if (m_ov && !out_ready && cnt < 65535) cnt++;
      if (flush) q.delete();
      else if (enable) begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) q.push_back(in_data);
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the clock edge.
  always @(negedge clk) begin
    logic e_ov, e_ir;
    e_ov = enable && (q.size() > 0);
    e_ir = enable && (q.size() < 2);
    chk("mon_out_valid", {63'd0, ov}, {63'd0, e_ov});
    chk("mon_in_ready", {63'd0, ir}, {63'd0, e_ir});
    chk("mon_stall_cnt", {48'd0, sc}, 64'(cnt));
    chk("mon_sat_cnt", {60'd0, sc4}, (cnt > 15) ? 64'd15 : 64'(cnt));
    chk("mon_sat_out_valid", {63'd0, ov4}, {63'd0, e_ov});
    if (e_ov && ov) begin
      chk("mon_out_data", od, q[0]);
      chk("mon_sat_out_data", od4, q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 64'h99; out_ready = 1'b0;

    // Reset
    step(); step();
    chk("rst_in_ready", {63'd0, ir}, 64'd1);
    chk("rst_out_valid", {63'd0, ov}, 64'd0);
    chk("rst_out_data", od, 64'd0);
    chk("rst_stall_cnt", {48'd0, sc}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Back-to-back stream
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hA; step();
    chk("stream_a", od, 64'hA);
    in_data = 64'hB; step();
    chk("stream_b", od, 64'hB);
    in_data = 64'hC; step();
    chk("stream_c", od, 64'hC);
    chk("stream_valid", {63'd0, ov}, 64'd1);
    in_valid = 1'b0; step();
    chk("stream_drain", {63'd0, ov}, 64'd0);

    // Skid under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; step();
    chk("skid_first", od, 64'h11);
    in_data = 64'h22; step();
    chk("skid_in_ready", {63'd0, ir}, 64'd0);
    chk("skid_hold", od, 64'h11);
    in_valid = 1'b0; step();
    chk("skid_hold2", od, 64'h11);
    chk("skid_cnt", {48'd0, sc}, 64'd2);
    out_ready = 1'b1; step();
    chk("skid_rel_22", od, 64'h22);
    step();
    chk("skid_empty", {63'd0, ov}, 64'd0);
    chk("skid_cnt_final", {48'd0, sc}, 64'd2);

    // Flush from SKID with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h33; step();
    in_data = 64'h44; step();
    flush = 1'b1; in_data = 64'h55; step();
    chk("flush_out_valid", {63'd0, ov}, 64'd0);
    chk("flush_in_ready", {63'd0, ir}, 64'd1);
    chk("flush_cnt", {48'd0, sc}, 64'd4);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("flush_no_55", {63'd0, ov}, 64'd0);

    // Freeze
    in_valid = 1'b1; in_data = 64'h66; step();
    in_valid = 1'b0; enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_out_valid", {63'd0, ov}, 64'd0);
      chk("frz_in_ready", {63'd0, ir}, 64'd0);
      chk("frz_data", od, 64'h66);
      chk("frz_cnt", {48'd0, sc}, 64'd4);
    end
    enable = 1'b1; #1;
    chk("frz_release_valid", {63'd0, ov}, 64'd1);
    step();
    chk("frz_once", {63'd0, ov}, 64'd0);
    chk("frz_cnt_after", {48'd0, sc}, 64'd4);

    // Counter saturation on the 4-bit instance
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h77; step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_cnt4", {60'd0, sc4}, (4 + i > 15) ? 64'd15 : 64'(4 + i));
    end
    chk("sat_cnt16", {48'd0, sc}, 64'd24);

    // Reset mid-stream
    in_valid = 1'b1; in_data = 64'h88; rst = 1'b1; step();
    chk("rst_mid_valid", {63'd0, ov}, 64'd0);
    chk("rst_mid_cnt", {48'd0, sc}, 64'd0);
    rst = 1'b0; in_valid = 1'b0; step();

    // Random soak against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 2047) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_data   = {$urandom, $urandom};
      step();
    end
    rst = 1'b0; flush = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
